// File: rtl/fnd_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit FND display.
// Each slot opens with a dead-time gap with all commons off. The frame value is latched once per frame.
module fnd_scan_controller #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [13:0] i_fndCounter,
  input  logic [3:0]  i_dotMask,
  output logic [1:0]  o_fndDigit,
  output logic [13:0] o_fndValue,
  output logic [3:0]  o_fndCom,
  output logic        o_fndDp,
  output logic        o_fndBlank,
  output logic        o_scanTick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BCNT_MAX  = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] CNT_ONE   = PW'(1);
  localparam logic [PW-1:0] CNT_ZERO  = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] bcnt_q, bcnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [13:0] value_q, value_d;
  logic        dot_q, dot_d;
  logic        blank_q, blank_d;
  logic        dp_q, dp_d;
  logic [3:0]  com_q, com_d;
  logic        tick_q, tick_d;
  logic        enter_blank_s;
  logic [13:0] sat_value_s;

  function automatic logic lead_zero(input logic [13:0] v, input logic [1:0] k);
    logic r;
    case (k)
      2'd1:    r = (v < 14'd10);
      2'd2:    r = (v < 14'd100);
      2'd3:    r = (v < 14'd1000);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign sat_value_s = (i_fndCounter > 14'd9999) ? 14'd9999 : i_fndCounter;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    bcnt_d        = bcnt_q;
    digit_d       = digit_q;
    value_d       = value_q;
    dot_d         = dot_q;
    blank_d       = blank_q;
    tick_d        = 1'b0;
    enter_blank_s = 1'b0;

    if (!i_enable) begin
      state_d = ST_IDLE;
      presc_d = CNT_ZERO;
      bcnt_d  = CNT_ZERO;
      digit_d = 2'd0;
      dot_d   = 1'b0;
      blank_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d       = ST_BLANK;
          presc_d       = CNT_ZERO;
          bcnt_d        = CNT_ZERO;
          digit_d       = 2'd0;
          value_d       = sat_value_s;
          enter_blank_s = 1'b1;
        end
        ST_BLANK: begin
          presc_d = presc_q + CNT_ONE;
          if (bcnt_q == BCNT_MAX) begin
            state_d = ST_SHOW;
          end else begin
            bcnt_d = bcnt_q + CNT_ONE;
          end
        end
        ST_SHOW: begin
          if (presc_q == PRESC_MAX) begin
            state_d       = ST_BLANK;
            presc_d       = CNT_ZERO;
            bcnt_d        = CNT_ZERO;
            digit_d       = digit_q + 2'd1;
            tick_d        = 1'b1;
            enter_blank_s = 1'b1;
            if (digit_q == 2'd3) begin
              value_d = sat_value_s;
            end else begin
              value_d = value_q;
            end
          end else begin
            presc_d = presc_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = CNT_ZERO;
          bcnt_d  = CNT_ZERO;
          digit_d = 2'd0;
        end
      endcase
    end

    // Dot and blank flags follow the digit, using the value that frame will show
    if (enter_blank_s) begin
      dot_d   = i_dotMask[digit_d];
      blank_d = lead_zero(value_d, digit_d);
    end else begin
      dot_d   = dot_d;
      blank_d = blank_d;
    end

    if ((state_d == ST_SHOW) && !blank_d) begin
      com_d = ~(4'b0001 << digit_d);
    end else begin
      com_d = 4'b1111;
    end
    dp_d = (state_d == ST_SHOW) && dot_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      presc_q <= CNT_ZERO;
      bcnt_q  <= CNT_ZERO;
      digit_q <= 2'd0;
      value_q <= 14'd0;
      dot_q   <= 1'b0;
      blank_q <= 1'b0;
      dp_q    <= 1'b0;
      com_q   <= 4'b1111;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      digit_q <= digit_d;
      value_q <= value_d;
      dot_q   <= dot_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      com_q   <= com_d;
      tick_q  <= tick_d;
    end
  end

  assign o_fndDigit = digit_q;
  assign o_fndValue = value_q;
  assign o_fndCom   = com_q;
  assign o_fndDp    = dp_q;
  assign o_fndBlank = blank_q;
  assign o_scanTick = tick_q;

endmodule
